burst_memory: RTL and testbench

- Parametrised successor to the single-word instruction/data memory.
- Byte-addressable, big-endian, 32-bit word port with burst reads and writes of 1, 4, 8 or 16 words, selected by access_size.
- Adds an explicit burst FSM, a registered read-valid strobe, range/alignment error reporting, write-bypass selection per beat, and branch-flush abort of read bursts.
- Serves as the shared fetch/load-store memory behind the pipeline.

---
 rtl/burst_memory_pkg.sv | 30 +++
 rtl/burst_memory_if.sv | 28 ++
 rtl/burst_memory_mem.sv | 36 +++
 rtl/burst_memory.sv | 152 +++++++++++++++
 tb/tb_burst_memory.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/burst_memory_pkg.sv
// Shared types and constants for the burst memory: access-size encoding,
// burst FSM states and the burst-length decode.
package burst_memory_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BEAT_CNT_W = 4;

    localparam logic [1:0] ACC_1  = 2'b00;
    localparam logic [1:0] ACC_4  = 2'b01;
    localparam logic [1:0] ACC_8  = 2'b10;
    localparam logic [1:0] ACC_16 = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST
    } state_t;

    function automatic logic [4:0] burst_len(input logic [1:0] access_size);
        logic [4:0] len;
        unique case (access_size)
            ACC_1:   len = 5'd1;
            ACC_4:   len = 5'd4;
            ACC_8:   len = 5'd8;
            default: len = 5'd16;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/burst_memory_if.sv
// Request/response bundle between a pipeline stage (master) and the burst memory (slave).
interface burst_memory_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] wm_bypass;
    logic              do_wm_bypass;
    logic [1:0]        access_size;
    logic              rw;
    logic              enable;
    logic              do_branch;
    logic              busy;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              err;

    modport master (
        output address, data_in, wm_bypass, do_wm_bypass, access_size, rw, enable, do_branch,
        input  busy, data_out, data_valid, err
    );

    modport slave (
        input  address, data_in, wm_bypass, do_wm_bypass, access_size, rw, enable, do_branch,
        output busy, data_out, data_valid, err
    );
endinterface

// File: rtl/burst_memory_mem.sv
// Byte-organised storage with one big-endian 32-bit word port:
// combinational read, write committed on the rising clock edge, no reset.
module mem_byte_array
    import burst_memory_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 1048576,
    parameter int unsigned AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [7:0]    mem [MEM_DEPTH];
    logic [AW-1:0] a1, a2, a3;

    always_comb begin
        a1 = addr + AW'(1);
        a2 = addr + AW'(2);
        a3 = addr + AW'(3);
    end

    assign rdata = {mem[addr], mem[a1], mem[a2], mem[a3]};

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata[31:24];
            mem[a1]   <= wdata[23:16];
            mem[a2]   <= wdata[15:8];
            mem[a3]   <= wdata[7:0];
        end
    end

endmodule

// File: rtl/burst_memory.sv
// Shared fetch/load-store memory: 1/4/8/16-word bursts, range/alignment
// rejection, per-beat write bypass and branch-flush abort of read bursts.
module burst_memory
    import burst_memory_pkg::*;
#(
    parameter int unsigned       MEM_DEPTH = 1048576,
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h80020000,
    parameter int unsigned       DATA_W    = 32
) (
    input logic           clock,
    input logic           reset_n,
    burst_memory_if.slave bus
);

    localparam int unsigned AW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned AW1 = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = AW1'(MEM_DEPTH);

    if (DATA_W != 32) begin : g_data_w_check
        $error("burst_memory: DATA_W must be 32");
    end

    state_t                state_q, state_d;
    logic [BEAT_CNT_W-1:0] beat_q, beat_d;
    logic [BEAT_CNT_W-1:0] last_q, last_d;
    logic [AW-1:0]         ptr_q, ptr_d;
    logic [DATA_W-1:0]     dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;

    logic [ADDR_W:0]       offset;
    logic [ADDR_W:0]       span;
    logic [4:0]            len;
    logic                  reject;
    logic                  mem_we;
    logic [AW-1:0]         mem_addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W-1:0]     rdata;

    // Extra top bit keeps offset + 4*L from wrapping near the top of the address space.
    assign len    = burst_len(bus.access_size);
    assign offset = {1'b0, bus.address} - {1'b0, BASE_ADDR};
    assign span   = AW1'({len, 2'b00});
    assign reject = (bus.address[1:0] != 2'b00)
                 || (bus.address < BASE_ADDR)
                 || ((offset + span) > DEPTH_EXT);

    assign wdata = bus.do_wm_bypass ? bus.wm_bypass : bus.data_in;

    mem_byte_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (AW)
    ) u_mem (
        .clock (clock),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (wdata),
        .rdata (rdata)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            last_q  <= '0;
            ptr_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
            ptr_q   <= ptr_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        last_d   = last_q;
        ptr_d    = ptr_q;
        dout_d   = dout_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        mem_we   = 1'b0;
        mem_addr = ptr_q;

        unique case (state_q)
            IDLE: begin
                // Beat 0 is served straight from the request address; later beats use ptr_q.
                mem_addr = offset[AW-1:0];
                if (bus.enable) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        ptr_d  = offset[AW-1:0] + AW'(4);
                        beat_d = BEAT_CNT_W'(1);
                        last_d = BEAT_CNT_W'(len - 5'd1);
                        if (bus.rw) begin
                            valid_d = 1'b1;
                            dout_d  = bus.do_branch ? '0 : rdata;
                            if (len != 5'd1 && !bus.do_branch) begin
                                state_d = RD_BURST;
                            end
                        end else begin
                            mem_we = 1'b1;
                            if (len != 5'd1) begin
                                state_d = WR_BURST;
                            end
                        end
                    end
                end
            end

            RD_BURST: begin
                valid_d = 1'b1;
                dout_d  = bus.do_branch ? '0 : rdata;
                ptr_d   = ptr_q + AW'(4);
                beat_d  = beat_q + BEAT_CNT_W'(1);
                if (bus.do_branch || beat_q == last_q) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end
            end

            WR_BURST: begin
                mem_we = 1'b1;
                ptr_d  = ptr_q + AW'(4);
                beat_d = beat_q + BEAT_CNT_W'(1);
                if (beat_q == last_q) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.data_out   = dout_q;
    assign bus.data_valid = valid_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_burst_memory.sv
// Self-checking bench for burst_memory: directed scenarios plus randomized
// write/read-back bursts against a word-addressed reference memory.
module tb_burst_memory;
    import burst_memory_pkg::*;

    localparam int unsigned DEPTH = 1048576;
    localparam logic [31:0] BASE  = 32'h80020000;
    localparam logic [31:0] TOP   = BASE + DEPTH;

    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    logic [31:0] model [logic [31:0]];

    burst_memory_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    burst_memory #(
        .MEM_DEPTH (DEPTH),
        .ADDR_W    (32),
        .BASE_ADDR (BASE),
        .DATA_W    (32)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int blen(input logic [1:0] acc);
        case (acc)
            2'd0:    return 1;
            2'd1:    return 4;
            2'd2:    return 8;
            default: return 16;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [1:0] acc, input int mode,
                            input logic [31:0] cval, input logic [15:0] bp_mask,
                            input logic [31:0] bp_val);
        int n;
        logic [31:0] d;
        n = blen(acc);
        for (int k = 0; k < n; k++) begin
            d = (mode == 1) ? 32'(k + 1) : (mode == 2) ? cval : $urandom;
            bus.data_in      = d;
            bus.wm_bypass    = bp_val;
            bus.do_wm_bypass = bp_mask[k];
            bus.do_branch    = 1'($urandom_range(0, 1));
            if (k == 0) begin
                bus.address     = addr;
                bus.access_size = acc;
                bus.rw          = 1'b0;
                bus.enable      = 1'b1;
            end else begin
                bus.address = $urandom;
                bus.rw      = 1'($urandom_range(0, 1));
                bus.enable  = 1'($urandom_range(0, 1));
            end
            cyc();
            bus.enable = 1'b0;
            model[addr + 32'(4 * k)] = bp_mask[k] ? bp_val : d;
            check("wr_busy", 32'(bus.busy), 32'(k < n - 1));
            check("wr_valid", 32'(bus.data_valid), 32'd0);
            check("wr_err", 32'(bus.err), 32'd0);
        end
        bus.do_branch    = 1'b0;
        bus.do_wm_bypass = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [1:0] acc, input int flush);
        int n;
        logic [31:0] exp;
        n = blen(acc);
        bus.address     = addr;
        bus.access_size = acc;
        bus.rw          = 1'b1;
        bus.enable      = 1'b1;
        bus.do_branch   = (flush == 0);
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                bus.address   = $urandom;
                bus.rw        = 1'($urandom_range(0, 1));
                bus.enable    = 1'($urandom_range(0, 1));
                bus.do_branch = (k == flush);
            end
            cyc();
            bus.enable    = 1'b0;
            bus.do_branch = 1'b0;
            exp = (k == flush) ? 32'd0 : model[addr + 32'(4 * k)];
            check("rd_valid", 32'(bus.data_valid), 32'd1);
            check("rd_data", bus.data_out, exp);
            check("rd_busy", 32'(bus.busy), 32'((k < n - 1) && (k != flush)));
            if (k == flush) break;
        end
        cyc();
        check("rd_valid_end", 32'(bus.data_valid), 32'd0);
        check("rd_busy_end", 32'(bus.busy), 32'd0);
    endtask

    task automatic do_bad(input logic [31:0] addr, input logic [1:0] acc, input logic rw);
        bus.address     = addr;
        bus.access_size = acc;
        bus.rw          = rw;
        bus.enable      = 1'b1;
        bus.data_in     = $urandom;
        cyc();
        bus.enable = 1'b0;
        check("bad_err", 32'(bus.err), 32'd1);
        check("bad_busy", 32'(bus.busy), 32'd0);
        check("bad_valid", 32'(bus.data_valid), 32'd0);
        cyc();
        check("bad_err_pulse", 32'(bus.err), 32'd0);
        check("bad_valid2", 32'(bus.data_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] addr;
        logic [1:0]  acc;
        int          fl;

        n_checks         = 0;
        n_fail           = 0;
        reset_n          = 1'b1;
        bus.address      = '0;
        bus.data_in      = '0;
        bus.wm_bypass    = '0;
        bus.do_wm_bypass = 1'b0;
        bus.access_size  = 2'b00;
        bus.rw           = 1'b0;
        bus.enable       = 1'b0;
        bus.do_branch    = 1'b0;

        #2 reset_n = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_dout", bus.data_out, 32'd0);
        check("rst_valid", 32'(bus.data_valid), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        cyc();

        // Single word write then read, big-endian byte order
        do_write(BASE, 2'b00, 2, 32'hDEADBEEF, 16'h0000, 32'h0);
        do_read(BASE, 2'b00, -1);
        check("byte0", 32'(dut.u_mem.mem[0]), 32'h000000DE);
        check("byte3", 32'(dut.u_mem.mem[3]), 32'h000000EF);

        // 8-word burst of 1..8
        do_write(BASE + 32'h40, 2'b10, 1, 32'h0, 16'h0000, 32'h0);
        do_read(BASE + 32'h40, 2'b10, -1);

        // Bypass on beat 2 only
        do_write(BASE + 32'h80, 2'b01, 0, 32'h0, 16'h0004, 32'hCAFE0000);
        check("bypass_model", model[BASE + 32'h88], 32'hCAFE0000);
        do_read(BASE + 32'h80, 2'b01, -1);

        // 16-word read flushed on beat 5, followed by a fresh read
        do_write(BASE + 32'h100, 2'b11, 0, 32'h0, 16'h0000, 32'h0);
        do_read(BASE + 32'h100, 2'b11, 5);
        do_read(BASE + 32'h100, 2'b11, -1);
        do_read(BASE + 32'h100, 2'b01, 0);

        // Rejected requests
        do_bad(32'h80020002, 2'b00, 1'b1);
        do_bad(32'h8001FFFC, 2'b00, 1'b1);
        do_bad(32'h00000000, 2'b01, 1'b0);
        do_bad(32'hFFFFFFFC, 2'b11, 1'b1);

        // Top-of-memory boundary: last legal 4-word burst, then an overrun write
        do_write(TOP - 32'd16, 2'b01, 0, 32'h0, 16'h0000, 32'h0);
        do_read(TOP - 32'd16, 2'b01, -1);
        do_write(TOP - 32'd8, 2'b00, 2, 32'h11111111, 16'h0000, 32'h0);
        do_write(TOP - 32'd4, 2'b00, 2, 32'h22222222, 16'h0000, 32'h0);
        do_bad(TOP - 32'd8, 2'b01, 1'b0);
        do_read(TOP - 32'd8, 2'b00, -1);
        do_read(TOP - 32'd4, 2'b00, -1);
        do_read(TOP - 32'd16, 2'b01, -1);

        // Reset during beat 3 of an 8-word write
        addr = BASE + 32'h400;
        do_write(addr, 2'b11, 0, 32'h0, 16'h0000, 32'h0);
        for (int k = 0; k < 3; k++) begin
            bus.data_in = $urandom;
            if (k == 0) begin
                bus.address     = addr;
                bus.access_size = 2'b10;
                bus.rw          = 1'b0;
                bus.enable      = 1'b1;
            end
            cyc();
            bus.enable = 1'b0;
            model[addr + 32'(4 * k)] = bus.data_in;
            check("mr_busy", 32'(bus.busy), 32'd1);
        end
        bus.data_in = $urandom;
        reset_n = 1'b0;
        #1;
        check("mr_busy_rst", 32'(bus.busy), 32'd0);
        check("mr_state_rst", 32'(dut.state_q), 32'(IDLE));
        check("mr_valid_rst", 32'(bus.data_valid), 32'd0);
        cyc();
        reset_n = 1'b1;
        cyc();
        check("mr_busy_after", 32'(bus.busy), 32'd0);
        do_read(addr, 2'b00, -1);
        do_read(addr + 32'd4, 2'b00, -1);
        do_read(addr + 32'd8, 2'b00, -1);
        do_read(addr, 2'b11, -1);

        // Randomized write/read-back bursts with occasional flush and bad requests
        for (int i = 0; i < 24; i++) begin
            acc  = 2'($urandom_range(0, 3));
            addr = BASE + 32'h2000 + 32'(4 * $urandom_range(0, 511));
            do_write(addr, acc, 0, 32'h0, 16'($urandom), $urandom);
            fl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, blen(acc) - 1)) : -1;
            do_read(addr, acc, fl);
            if ($urandom_range(0, 3) == 0) begin
                do_bad(addr | 32'($urandom_range(1, 3)), acc, 1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 3) == 0) begin
                do_bad(BASE - 32'(4 * $urandom_range(1, 64)), acc, 1'($urandom_range(0, 1)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
